// File: rtl/game_pkg.sv
// Shared types and default timing constants for the binary number game blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } chk_state_t;

    localparam int NIBBLE_W = 4;

    localparam int DEF_SCORE_W        = 8;
    localparam int DEF_RESULT_CYCLES  = 25_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 250_000_000;

    // Bits needed to hold a count of 0..n-1
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/answer_checker_if.sv
// Player/generator handshake bundle for answer_checker.
interface answer_checker_if
    import game_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W
);
    logic                start;
    logic                submit;
    logic [NIBBLE_W-1:0] gen_value;
    logic [NIBBLE_W-1:0] guess;
    logic                gen_enable;
    logic [NIBBLE_W-1:0] target;
    logic                busy;
    logic                correct;
    logic                wrong;
    logic                timed_out;
    logic [SCORE_W-1:0]  score;

    modport master (
        output start, submit, gen_value, guess,
        input  gen_enable, target, busy, correct, wrong, timed_out, score
    );

    modport slave (
        input  start, submit, gen_value, guess,
        output gen_enable, target, busy, correct, wrong, timed_out, score
    );
endinterface

// File: rtl/answer_checker_round_timer.sv
// One-shot cycle counter: counts while run, parks at limit, expired while sitting there.
module round_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt;

    assign expired = run && (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/answer_checker.sv
// Round controller for the binary number game: latch target, judge guess, keep score.
// Optional guess window enabled by defining ANSWER_TIMEOUT_EN.
module answer_checker
    import game_pkg::*;
#(
    parameter int SCORE_W        = DEF_SCORE_W,
    parameter int RESULT_CYCLES  = DEF_RESULT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              rst_n,
    answer_checker_if.slave  bus
);
    localparam int               RES_W     = cnt_w(RESULT_CYCLES);
    localparam logic [RES_W-1:0] RES_LIMIT = RES_W'(RESULT_CYCLES - 1);

    chk_state_t          state_q, state_d;
    logic [NIBBLE_W-1:0] target_q, target_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                correct_q, correct_d;
    logic                wrong_q, wrong_d;
    logic                tmo_q, tmo_d;
    logic                busy_q, busy_d;
    logic                gen_en_q, gen_en_d;
    logic                hold_done;
    logic                tmo_expired;

    round_timer #(.W(RES_W)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != RESULT),
        .run     (state_q == RESULT),
        .limit   (RES_LIMIT),
        .expired (hold_done)
    );

`ifdef ANSWER_TIMEOUT_EN
    localparam int               TMO_W     = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

    // Timer is held clear outside WAIT, so every round starts its window at zero
    round_timer #(.W(TMO_W)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q != WAIT),
        .run     (state_q == WAIT),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            score_q   <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            gen_en_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            score_q   <= score_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            gen_en_q  <= gen_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = WAIT;
            WAIT:    if (bus.submit || tmo_expired) state_d = RESULT;
            RESULT:  if (hold_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; start beats submit in IDLE by construction
    always_comb begin
        target_d  = target_q;
        score_d   = score_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        tmo_d     = tmo_q;
        busy_d    = (state_d != IDLE);
        gen_en_d  = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    target_d  = bus.gen_value;
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    tmo_d     = 1'b0;
                end
            end
            WAIT: begin
                if (bus.submit) begin
                    if (bus.guess == target_q) begin
                        correct_d = 1'b1;
                        if (score_q != {SCORE_W{1'b1}})
                            score_d = score_q + 1'b1;
                    end else begin
                        wrong_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    wrong_d = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
            RESULT: begin
                if (hold_done) begin
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    tmo_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.target     = target_q;
    assign bus.score      = score_q;
    assign bus.correct    = correct_q;
    assign bus.wrong      = wrong_q;
    assign bus.timed_out  = tmo_q;
    assign bus.busy       = busy_q;
    assign bus.gen_enable = gen_en_q;
endmodule

// File: tb/tb_answer_checker.sv
// Randomized self-checking bench for answer_checker against a round-level score model.
module tb_answer_checker;
    localparam int SW = 3;
    localparam int RC = 4;
    localparam int TC = 8;
    localparam int MAX_SCORE = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    answer_checker_if #(.SCORE_W(SW)) bus();

    answer_checker #(
        .SCORE_W        (SW),
        .RESULT_CYCLES  (RC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full round: start with gv, idle in WAIT for pre_wait cycles, submit g, ride out RESULT
    task automatic play_round(input logic [3:0] gv, input logic [3:0] g, input int pre_wait);
        bit match;
        bus.gen_value = gv; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.gen_value = 4'($urandom);
        checks++; if (bus.target !== gv) begin errors++; $display("FAIL round_target: got %0d want %0d", bus.target, gv); end
        checks++; if (bus.busy !== 1'b1 || bus.gen_enable !== 1'b0) begin errors++; $display("FAIL round_wait_state: busy=%b gen_en=%b want 1/0", bus.busy, bus.gen_enable); end
        checks++; if (bus.correct !== 1'b0 || bus.wrong !== 1'b0) begin errors++; $display("FAIL round_flags_clear: c=%b w=%b want 0/0", bus.correct, bus.wrong); end
        repeat (pre_wait) begin bus.guess = 4'($urandom); tick(); end
        bus.guess = g; bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0; bus.guess = 4'($urandom);
        match = (g == gv);
        if (match && exp_score < MAX_SCORE) exp_score++;
        for (int i = 0; i < RC; i++) begin
            checks++; if (bus.correct !== match || bus.wrong !== !match || bus.timed_out !== 1'b0) begin
                errors++; $display("FAIL round_result_flags[%0d]: c=%b w=%b t=%b want %b/%b/0", i, bus.correct, bus.wrong, bus.timed_out, match, !match); end
            checks++; if (bus.score !== SW'(exp_score) || bus.busy !== 1'b1) begin
                errors++; $display("FAIL round_result_score[%0d]: score=%0d busy=%b want %0d/1", i, bus.score, bus.busy, exp_score); end
            bus.start = 1'($urandom_range(0, 1)); bus.submit = 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0; bus.submit = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.gen_enable !== 1'b1 || bus.correct !== 1'b0 || bus.wrong !== 1'b0) begin
            errors++; $display("FAIL round_back_idle: busy=%b gen_en=%b c=%b w=%b want 0/1/0/0", bus.busy, bus.gen_enable, bus.correct, bus.wrong); end
        checks++; if (bus.score !== SW'(exp_score)) begin errors++; $display("FAIL round_idle_score: got %0d want %0d", bus.score, exp_score); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.gen_enable !== 1'b1 || bus.busy !== 1'b0 || bus.score !== '0 || bus.target !== '0) begin
            errors++; $display("FAIL reset_outputs: gen_en=%b busy=%b score=%0d target=%0d want 1/0/0/0", bus.gen_enable, bus.busy, bus.score, bus.target); end
        checks++; if (bus.correct !== 1'b0 || bus.wrong !== 1'b0 || bus.timed_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags: c=%b w=%b t=%b want 0", bus.correct, bus.wrong, bus.timed_out); end
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        checks++; if (bus.gen_enable !== 1'b1 || bus.busy !== 1'b0 || bus.score !== '0) begin
            errors++; $display("FAIL reset_release: gen_en=%b busy=%b score=%0d want 1/0/0", bus.gen_enable, bus.busy, bus.score); end
        exp_score = 0;
    endtask

    task automatic test_correct();
        play_round(4'd9, 4'd9, 2);
    endtask

    task automatic test_wrong();
        play_round(4'd5, 4'd4, 1);
    endtask

    task automatic test_idle_inputs();
        logic [3:0] gv;
        bus.guess = bus.target; bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.correct !== 1'b0 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL idle_submit: busy=%b c=%b score=%0d want 0/0/%0d", bus.busy, bus.correct, bus.score, exp_score); end
        gv = 4'($urandom);
        bus.gen_value = gv; bus.guess = gv; bus.start = 1'b1; bus.submit = 1'b1;
        tick();
        bus.start = 1'b0; bus.submit = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.correct !== 1'b0 || bus.wrong !== 1'b0 || bus.target !== gv) begin
            errors++; $display("FAIL start_submit_same: busy=%b c=%b w=%b tgt=%0d want 1/0/0/%0d", bus.busy, bus.correct, bus.wrong, bus.target, gv); end
        bus.gen_value = ~gv; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.target !== gv || bus.busy !== 1'b1 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL wait_start_ignored: tgt=%0d busy=%b score=%0d want %0d/1/%0d", bus.target, bus.busy, bus.score, gv, exp_score); end
        bus.guess = gv ^ 4'h1; bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        checks++; if (bus.wrong !== 1'b1 || bus.correct !== 1'b0 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL wait_wrong_guess: w=%b c=%b score=%0d want 1/0/%0d", bus.wrong, bus.correct, bus.score, exp_score); end
        repeat (RC) tick();
        checks++; if (bus.busy !== 1'b0 || bus.gen_enable !== 1'b1) begin
            errors++; $display("FAIL idle_after_wrong: busy=%b gen_en=%b want 0/1", bus.busy, bus.gen_enable); end
    endtask

    task automatic test_random();
        logic [3:0] gv, g;
        for (int r = 0; r < 12; r++) begin
            gv = 4'($urandom);
            g  = ($urandom_range(0, 1) == 1) ? gv : 4'($urandom);
            play_round(gv, g, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_saturate();
        logic [3:0] gv;
        for (int r = 0; r < 8; r++) begin
            gv = 4'($urandom);
            play_round(gv, gv, int'($urandom_range(0, 3)));
        end
        checks++; if (bus.score !== SW'(MAX_SCORE)) begin errors++; $display("FAIL score_saturated: got %0d want %0d", bus.score, MAX_SCORE); end
        bus.gen_value = 4'hA; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_score = 0;
        checks++; if (bus.busy !== 1'b0 || bus.gen_enable !== 1'b1 || bus.score !== '0 || bus.target !== '0) begin
            errors++; $display("FAIL reset_mid_wait: busy=%b gen_en=%b score=%0d tgt=%0d want 0/1/0/0", bus.busy, bus.gen_enable, bus.score, bus.target); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        play_round(4'd3, 4'd3, 0);
    endtask

    task automatic test_timeout();
        bus.gen_value = 4'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
        repeat (TC - 1) tick();
        checks++; if (bus.busy !== 1'b1 || bus.wrong !== 1'b0 || bus.timed_out !== 1'b0) begin
            errors++; $display("FAIL tmo_before_limit: busy=%b w=%b t=%b want 1/0/0", bus.busy, bus.wrong, bus.timed_out); end
        tick();
        checks++; if (bus.wrong !== 1'b1 || bus.timed_out !== 1'b1 || bus.correct !== 1'b0 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL tmo_expired: w=%b t=%b c=%b score=%0d want 1/1/0/%0d", bus.wrong, bus.timed_out, bus.correct, bus.score, exp_score); end
        repeat (RC) tick();
        bus.gen_value = 4'd11; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (TC - 1) tick();
        bus.guess = 4'd11; bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        if (exp_score < MAX_SCORE) exp_score++;
        checks++; if (bus.correct !== 1'b1 || bus.timed_out !== 1'b0 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL tmo_submit_wins: c=%b t=%b score=%0d want 1/0/%0d", bus.correct, bus.timed_out, bus.score, exp_score); end
        repeat (RC) tick();
`else
        repeat (3 * TC) tick();
        checks++; if (bus.busy !== 1'b1 || bus.wrong !== 1'b0 || bus.timed_out !== 1'b0) begin
            errors++; $display("FAIL no_timeout_wait: busy=%b w=%b t=%b want 1/0/0", bus.busy, bus.wrong, bus.timed_out); end
        bus.guess = 4'd6; bus.submit = 1'b1;
        tick();
        bus.submit = 1'b0;
        if (exp_score < MAX_SCORE) exp_score++;
        checks++; if (bus.correct !== 1'b1 || bus.timed_out !== 1'b0 || bus.score !== SW'(exp_score)) begin
            errors++; $display("FAIL late_submit: c=%b t=%b score=%0d want 1/0/%0d", bus.correct, bus.timed_out, bus.score, exp_score); end
        repeat (RC) tick();
`endif
        checks++; if (bus.busy !== 1'b0 || bus.gen_enable !== 1'b1) begin
            errors++; $display("FAIL tmo_back_idle: busy=%b gen_en=%b want 0/1", bus.busy, bus.gen_enable); end
    endtask

    initial begin
        bus.start = 1'b0; bus.submit = 1'b0; bus.guess = '0; bus.gen_value = '0;
        test_reset();
        test_correct();
        test_wrong();
        test_idle_inputs();
        test_random();
        test_saturate();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
